// File: rtl/rgb2ycbcr_pkg.sv
// Shared constants, coefficient tables and FSM state type for the
// block RGB -> YCbCr converter.
package rgb2ycbcr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    localparam int OFFSET_LUMA_STUDIO = 16;
    localparam int OFFSET_CHROMA      = 128;
    localparam int LEVEL_SHIFT_VALUE  = 128;

    // Number of core-wide batches needed to cover one block.
    function automatic int n_batch(input int pixel_count, input int core_count);
        return pixel_count / core_count;
    endfunction

    // Matrix coefficients in millionths; idx = channel*3 + term,
    // channel 0/1/2 = Y/Cb/Cr, term 0/1/2 = R/G/B.
    function automatic longint coef_micro(input logic studio, input int idx);
        longint m;
        m = 0;
        if (!studio) begin
            case (idx)
                0: m = 299000;   1: m = 587000;   2: m = 114000;
                3: m = -168736;  4: m = -331264;  5: m = 500000;
                6: m = 500000;   7: m = -418688;  8: m = -81312;
                default: m = 0;
            endcase
        end else begin
            case (idx)
                0: m = 256788;   1: m = 504129;   2: m = 97906;
                3: m = -148223;  4: m = -290993;  5: m = 439216;
                6: m = 439216;   7: m = -367788;  8: m = -71427;
                default: m = 0;
            endcase
        end
        return m;
    endfunction

    // Round-to-nearest of coefficient * 2^frac, ties away from zero.
    function automatic longint coef_q(input logic studio, input int idx, input int frac);
        longint m;
        longint mag;
        longint q;
        m   = coef_micro(studio, idx);
        mag = (m < 0) ? -m : m;
        q   = ((mag <<< frac) + 64'sd500000) / 64'sd1000000;
        return (m < 0) ? -q : q;
    endfunction

endpackage

// File: rtl/rgb2ycbcr_core_pipe.sv
// One-pixel colour conversion core: exact fixed-point matrix product,
// offsets and optional level shift, delayed by CORE_LAT registers.
module rgb2ycbcr_core_pipe
    import rgb2ycbcr_pkg::*;
#(
    parameter int fixed_point_length = 32,
    parameter int FRAC_BITS          = 16,
    parameter int input_width        = 8,
    parameter int CORE_LAT           = 2
) (
    input  logic                          clk,
    input  logic [input_width-1:0]        r,
    input  logic [input_width-1:0]        g,
    input  logic [input_width-1:0]        b,
    input  logic                          mode,
    input  logic                          level_shift,
    output logic [fixed_point_length-1:0] y,
    output logic [fixed_point_length-1:0] cb,
    output logic [fixed_point_length-1:0] cr
);

    localparam int ACC_W = fixed_point_length + 2;

    localparam logic signed [ACC_W-1:0] OFF_LUMA_STUDIO =
        ACC_W'(longint'(OFFSET_LUMA_STUDIO) <<< FRAC_BITS);
    localparam logic signed [ACC_W-1:0] OFF_CHROMA =
        ACC_W'(longint'(OFFSET_CHROMA) <<< FRAC_BITS);
    localparam logic signed [ACC_W-1:0] SHIFT_AMOUNT =
        ACC_W'(longint'(LEVEL_SHIFT_VALUE) <<< FRAC_BITS);

    logic signed [ACC_W-1:0] coef_jfif   [9];
    logic signed [ACC_W-1:0] coef_studio [9];
    logic signed [ACC_W-1:0] sample      [3];
    logic signed [ACC_W-1:0] acc         [3];

    logic [fixed_point_length-1:0] y_pipe  [CORE_LAT];
    logic [fixed_point_length-1:0] cb_pipe [CORE_LAT];
    logic [fixed_point_length-1:0] cr_pipe [CORE_LAT];

    // Coefficients are elaboration-time constants; mode only selects between them.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_coef
            localparam longint CJ = coef_q(1'b0, gi, FRAC_BITS);
            localparam longint CS = coef_q(1'b1, gi, FRAC_BITS);
            assign coef_jfif[gi]   = ACC_W'(CJ);
            assign coef_studio[gi] = ACC_W'(CS);
        end
    endgenerate

    // Exact multiply-accumulate in the widened accumulator, then offset and shift.
    always_comb begin
        sample[0] = ACC_W'(r);
        sample[1] = ACC_W'(g);
        sample[2] = ACC_W'(b);
        for (int ch = 0; ch < 3; ch++) begin
            if (ch == 0) begin
                acc[ch] = mode ? OFF_LUMA_STUDIO : '0;
            end else begin
                acc[ch] = OFF_CHROMA;
            end
            for (int t = 0; t < 3; t++) begin
                acc[ch] = acc[ch] + sample[t] *
                          (mode ? coef_studio[ch*3+t] : coef_jfif[ch*3+t]);
            end
            if (level_shift) begin
                acc[ch] = acc[ch] - SHIFT_AMOUNT;
            end
        end
    end

    // Truncated results travel through a CORE_LAT-deep delay line.
    always_ff @(posedge clk) begin
        y_pipe[0]  <= acc[0][fixed_point_length-1:0];
        cb_pipe[0] <= acc[1][fixed_point_length-1:0];
        cr_pipe[0] <= acc[2][fixed_point_length-1:0];
        for (int k = 1; k < CORE_LAT; k++) begin
            y_pipe[k]  <= y_pipe[k-1];
            cb_pipe[k] <= cb_pipe[k-1];
            cr_pipe[k] <= cr_pipe[k-1];
        end
    end

    assign y  = y_pipe[CORE_LAT-1];
    assign cb = cb_pipe[CORE_LAT-1];
    assign cr = cr_pipe[CORE_LAT-1];

    // Guard bits above the output word are intentionally discarded.
    wire unused_acc_msbs = ^{acc[0][ACC_W-1:fixed_point_length],
                             acc[1][ACC_W-1:fixed_point_length],
                             acc[2][ACC_W-1:fixed_point_length]};

endmodule

// File: rtl/rgb2ycbcr_block_engine.sv
// Block colour converter: captures a pixel block, feeds it batch by batch
// through CORE_COUNT pipelined cores, collects results and hands the block
// off with a valid/ready handshake.
module rgb2ycbcr_block_engine
    import rgb2ycbcr_pkg::*;
#(
    parameter int fixed_point_length = 32,
    parameter int FRAC_BITS          = 16,
    parameter int input_width        = 8,
    parameter int PIXEL_COUNT        = 64,
    parameter int CORE_COUNT         = 8,
    parameter int CORE_LAT           = 2
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic                                      mode,
    input  logic                                      level_shift,
    input  logic [input_width*PIXEL_COUNT-1:0]        r_all,
    input  logic [input_width*PIXEL_COUNT-1:0]        g_all,
    input  logic [input_width*PIXEL_COUNT-1:0]        b_all,
    output logic [fixed_point_length*PIXEL_COUNT-1:0] y_all,
    output logic [fixed_point_length*PIXEL_COUNT-1:0] cb_all,
    output logic [fixed_point_length*PIXEL_COUNT-1:0] cr_all,
    output logic                                      busy,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic                                      done
);

    localparam int N_BATCH = n_batch(PIXEL_COUNT, CORE_COUNT);
    localparam int BW      = (N_BATCH > 1) ? $clog2(N_BATCH) : 1;
    localparam int DW      = $clog2(CORE_LAT + 1);
    localparam int FPL     = fixed_point_length;
    localparam int IW      = input_width;

    state_t                 state_reg;
    logic [BW-1:0]          batch_reg;
    logic [DW-1:0]          drain_reg;
    logic                   busy_reg;
    logic                   out_valid_reg;
    logic                   done_reg;
    logic                   mode_reg;
    logic                   level_shift_reg;
    logic [IW*PIXEL_COUNT-1:0]  r_cap_reg, g_cap_reg, b_cap_reg;
    logic [FPL*PIXEL_COUNT-1:0] y_all_reg, cb_all_reg, cr_all_reg;

    logic                   tag_valid_reg [CORE_LAT];
    logic [BW-1:0]          tag_batch_reg [CORE_LAT];

    logic [IW-1:0]  core_r  [CORE_COUNT];
    logic [IW-1:0]  core_g  [CORE_COUNT];
    logic [IW-1:0]  core_b  [CORE_COUNT];
    logic [FPL-1:0] core_y  [CORE_COUNT];
    logic [FPL-1:0] core_cb [CORE_COUNT];
    logic [FPL-1:0] core_cr [CORE_COUNT];

    // Control FSM: accept, issue batches, wait for the pipeline, hold for handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            batch_reg     <= '0;
            drain_reg     <= '0;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg  <= 1'b1;
                        batch_reg <= '0;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (batch_reg == BW'(N_BATCH - 1)) begin
                        drain_reg <= '0;
                        state_reg <= ST_DRAIN;
                    end else begin
                        batch_reg <= batch_reg + BW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_reg == DW'(CORE_LAT)) begin
                        out_valid_reg <= 1'b1;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_HOLD;
                    end else begin
                        drain_reg <= drain_reg + DW'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Snapshot of the request so the source may change while we convert.
    always_ff @(posedge clk) begin
        if (state_reg == ST_IDLE && start && !rst) begin
            r_cap_reg       <= r_all;
            g_cap_reg       <= g_all;
            b_cap_reg       <= b_all;
            mode_reg        <= mode;
            level_shift_reg <= level_shift;
        end
    end

    // Batch tags track which output slots the cores' current results belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CORE_LAT; k++) begin
                tag_valid_reg[k] <= 1'b0;
                tag_batch_reg[k] <= '0;
            end
        end else begin
            tag_valid_reg[0] <= (state_reg == ST_RUN);
            tag_batch_reg[0] <= batch_reg;
            for (int k = 1; k < CORE_LAT; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_batch_reg[k] <= tag_batch_reg[k-1];
            end
        end
    end

    // Batch mux and conversion cores.
    generate
        for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_core
            assign core_r[gi] = r_cap_reg[(int'(batch_reg)*CORE_COUNT + gi)*IW +: IW];
            assign core_g[gi] = g_cap_reg[(int'(batch_reg)*CORE_COUNT + gi)*IW +: IW];
            assign core_b[gi] = b_cap_reg[(int'(batch_reg)*CORE_COUNT + gi)*IW +: IW];

            rgb2ycbcr_core_pipe #(
                .fixed_point_length (fixed_point_length),
                .FRAC_BITS          (FRAC_BITS),
                .input_width        (input_width),
                .CORE_LAT           (CORE_LAT)
            ) u_core (
                .clk         (clk),
                .r           (core_r[gi]),
                .g           (core_g[gi]),
                .b           (core_b[gi]),
                .mode        (mode_reg),
                .level_shift (level_shift_reg),
                .y           (core_y[gi]),
                .cb          (core_cb[gi]),
                .cr          (core_cr[gi])
            );
        end
    endgenerate

    // Write-back demux: each returning batch lands in its own output slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_all_reg  <= '0;
            cb_all_reg <= '0;
            cr_all_reg <= '0;
        end else if (tag_valid_reg[CORE_LAT-1]) begin
            for (int c = 0; c < CORE_COUNT; c++) begin
                y_all_reg [(int'(tag_batch_reg[CORE_LAT-1])*CORE_COUNT + c)*FPL +: FPL] <= core_y[c];
                cb_all_reg[(int'(tag_batch_reg[CORE_LAT-1])*CORE_COUNT + c)*FPL +: FPL] <= core_cb[c];
                cr_all_reg[(int'(tag_batch_reg[CORE_LAT-1])*CORE_COUNT + c)*FPL +: FPL] <= core_cr[c];
            end
        end
    end

    assign y_all     = y_all_reg;
    assign cb_all    = cb_all_reg;
    assign cr_all    = cr_all_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_rgb2ycbcr_block_engine.sv
// Self-checking bench for rgb2ycbcr_block_engine: directed corner blocks,
// backpressure, reset mid-run and randomized blocks against a real-valued model.
module tb_rgb2ycbcr_block_engine;

    localparam int FPL = 32;
    localparam int IW  = 8;
    localparam int PC  = 64;
    localparam int EXP_LAT = 11;

    logic clk = 1'b0;
    logic rst, start, mode, level_shift, out_ready;
    logic [IW*PC-1:0]  r_all, g_all, b_all;
    logic [FPL*PC-1:0] y_all, cb_all, cr_all;
    logic busy, out_valid, done;

    int total = 0;
    int bad   = 0;

    logic [7:0] mr [PC];
    logic [7:0] mg [PC];
    logic [7:0] mb [PC];
    real gy [PC];
    real gcb[PC];
    real gcr[PC];

    always #5 clk = ~clk;

    rgb2ycbcr_block_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .level_shift (level_shift),
        .r_all       (r_all),
        .g_all       (g_all),
        .b_all       (b_all),
        .y_all       (y_all),
        .cb_all      (cb_all),
        .cr_all      (cr_all),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done)
    );

    function automatic logic [31:0] word_of(input logic [FPL*PC-1:0] v, input int i);
        return v[i*FPL +: FPL];
    endfunction

    function automatic real real_of(input logic [FPL*PC-1:0] v, input int i);
        logic [31:0] w;
        w = v[i*FPL +: FPL];
        return $itor($signed(w));
    endfunction

    function automatic real absr(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic drive_ports_from_model();
        for (int i = 0; i < PC; i++) begin
            r_all[i*IW +: IW] = mr[i];
            g_all[i*IW +: IW] = mg[i];
            b_all[i*IW +: IW] = mb[i];
        end
    endtask

    task automatic load_uniform(input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv);
        for (int i = 0; i < PC; i++) begin
            mr[i] = rv; mg[i] = gv; mb[i] = bv;
        end
        drive_ports_from_model();
    endtask

    task automatic load_random();
        for (int i = 0; i < PC; i++) begin
            mr[i] = 8'($urandom_range(0, 255));
            mg[i] = 8'($urandom_range(0, 255));
            mb[i] = 8'($urandom_range(0, 255));
        end
        drive_ports_from_model();
    endtask

    // Scrambles the input ports only; the model keeps the captured block.
    task automatic scramble_ports();
        for (int i = 0; i < PC; i++) begin
            r_all[i*IW +: IW] = 8'($urandom);
            g_all[i*IW +: IW] = 8'($urandom);
            b_all[i*IW +: IW] = 8'($urandom);
        end
    endtask

    // Reference: the colour matrices in real arithmetic, scaled to Q16.16.
    task automatic golden(input logic m, input logic s);
        real rr, gg, bb, yv, cbv, crv;
        for (int i = 0; i < PC; i++) begin
            rr = $itor(mr[i]); gg = $itor(mg[i]); bb = $itor(mb[i]);
            if (!m) begin
                yv  = 0.299 * rr + 0.587 * gg + 0.114 * bb;
                cbv = 128.0 - 0.168736 * rr - 0.331264 * gg + 0.5 * bb;
                crv = 128.0 + 0.5 * rr - 0.418688 * gg - 0.081312 * bb;
            end else begin
                yv  = 16.0 + 0.256788 * rr + 0.504129 * gg + 0.097906 * bb;
                cbv = 128.0 - 0.148223 * rr - 0.290993 * gg + 0.439216 * bb;
                crv = 128.0 + 0.439216 * rr - 0.367788 * gg - 0.071427 * bb;
            end
            if (s) begin
                yv = yv - 128.0; cbv = cbv - 128.0; crv = crv - 128.0;
            end
            gy[i] = yv * 65536.0; gcb[i] = cbv * 65536.0; gcr[i] = crv * 65536.0;
        end
    endtask

    task automatic launch(input logic m, input logic s);
        @(negedge clk);
        mode = m; level_shift = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat, output int dones);
        lat = -1; dones = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 1'b0; level_shift = 1'b0; out_ready = 1'b0;
        load_uniform(8'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, out_valid, done} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {busy, out_valid, done});
        end
        total++;
        if (y_all !== '0 || cb_all !== '0 || cr_all !== '0) begin
            bad++; $display("FAIL reset_data: got y0=%h cb0=%h cr0=%h want 0", word_of(y_all, 0), word_of(cb_all, 0), word_of(cr_all, 0));
        end
        $display("reset: checked flags and outputs");
    endtask

    task automatic test_jfif_zero();
        int lat, dones, errs;
        load_uniform(8'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        launch(1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy: got %b want 1", busy); end
        wait_valid(lat, dones);
        total++;
        if (lat !== EXP_LAT) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, EXP_LAT); end
        total++;
        if (dones !== 1) begin bad++; $display("FAIL zero_done: got %0d pulses want 1", dones); end
        errs = 0;
        for (int i = 0; i < PC; i++)
            if (word_of(y_all, i) !== 32'h0 || word_of(cb_all, i) !== 32'h0080_0000 || word_of(cr_all, i) !== 32'h0080_0000) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL zero_data: got %0d bad pixels (y0=%h cb0=%h) want 0 (0 / 00800000)", errs, word_of(y_all, 0), word_of(cb_all, 0)); end
        @(negedge clk);
        total++;
        if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL zero_handshake: got valid,busy=%b want 00", {out_valid, busy}); end
        $display("jfif zero block: latency %0d", lat);
    endtask

    task automatic test_jfif_white();
        int lat, dones, errs;
        load_uniform(8'd255, 8'd255, 8'd255);
        mr[5] = 8'd255; mg[5] = 8'd0; mb[5] = 8'd0;
        drive_ports_from_model();
        out_ready = 1'b1;
        launch(1'b0, 1'b0);
        wait_valid(lat, dones);
        total++;
        if (lat !== EXP_LAT) begin bad++; $display("FAIL white_latency: got %0d want %0d", lat, EXP_LAT); end
        errs = 0;
        for (int i = 0; i < PC; i++)
            if (i != 5 && (word_of(y_all, i) !== 32'h00FF_0000 || word_of(cb_all, i) !== 32'h0080_0000 || word_of(cr_all, i) !== 32'h0080_0000)) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL white_data: got %0d bad pixels (y0=%h) want 00ff0000", errs, word_of(y_all, 0)); end
        total++;
        if (word_of(y_all, 5) !== 32'h004C_3E75) begin bad++; $display("FAIL red_pixel_y5: got %h want 004c3e75", word_of(y_all, 5)); end
        @(negedge clk);
        $display("jfif white block with red pixel 5: y5=%h", word_of(y_all, 5));
    endtask

    task automatic test_studio_and_shift();
        int lat, dones, errs;
        load_uniform(8'd0, 8'd0, 8'd0);
        out_ready = 1'b1;
        launch(1'b1, 1'b0);
        wait_valid(lat, dones);
        errs = 0;
        for (int i = 0; i < PC; i++)
            if (word_of(y_all, i) !== 32'h0010_0000 || word_of(cb_all, i) !== 32'h0080_0000 || word_of(cr_all, i) !== 32'h0080_0000) errs++;
        total++;
        if (errs != 0 || lat !== EXP_LAT) begin bad++; $display("FAIL studio_zero: got %0d bad pixels y0=%h lat=%0d want 00100000 lat 11", errs, word_of(y_all, 0), lat); end
        @(negedge clk);
        launch(1'b0, 1'b1);
        wait_valid(lat, dones);
        errs = 0;
        for (int i = 0; i < PC; i++)
            if (word_of(y_all, i) !== 32'hFF80_0000 || word_of(cb_all, i) !== 32'h0 || word_of(cr_all, i) !== 32'h0) errs++;
        total++;
        if (errs != 0 || lat !== EXP_LAT) begin bad++; $display("FAIL shift_zero: got %0d bad pixels y0=%h cb0=%h lat=%0d want ff800000/0", errs, word_of(y_all, 0), word_of(cb_all, 0), lat); end
        @(negedge clk);
        $display("studio zero and jfif level-shift zero blocks done");
    endtask

    task automatic test_backpressure();
        int lat, dones, extra_done, unstable;
        real err, worst;
        logic [FPL*PC-1:0] sy, scb, scr;
        load_random();
        golden(1'b1, 1'b1);
        out_ready = 1'b0;
        launch(1'b1, 1'b1);
        wait_valid(lat, dones);
        total++;
        if (lat !== EXP_LAT || dones !== 1) begin bad++; $display("FAIL bp_first_valid: got lat=%0d done=%0d want 11 / 1", lat, dones); end
        sy = y_all; scb = cb_all; scr = cr_all;
        worst = 0.0;
        for (int i = 0; i < PC; i++) begin
            err = absr(real_of(sy, i) - gy[i]);   if (err > worst) worst = err;
            err = absr(real_of(scb, i) - gcb[i]); if (err > worst) worst = err;
            err = absr(real_of(scr, i) - gcr[i]); if (err > worst) worst = err;
        end
        total++;
        if (worst > 32768.0) begin bad++; $display("FAIL bp_golden: got worst error %0f want <= 32768", worst); end
        extra_done = 0; unstable = 0;
        for (int c = 0; c < 20; c++) begin
            start = 1'($urandom);
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || y_all !== sy || cb_all !== scb || cr_all !== scr) unstable++;
        end
        total++;
        if (unstable != 0) begin bad++; $display("FAIL bp_hold_stable: got %0d unstable cycles want 0", unstable); end
        total++;
        if (extra_done != 0) begin bad++; $display("FAIL bp_single_done: got %0d extra pulses want 0", extra_done); end
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        total++;
        if ({out_valid, busy} !== 2'b00) begin bad++; $display("FAIL bp_release: got valid,busy=%b want 00", {out_valid, busy}); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || y_all !== sy) begin bad++; $display("FAIL bp_start_ignored: got busy=%b y0=%h want 0 / %h", busy, word_of(y_all, 0), word_of(sy, 0)); end
        $display("backpressure: 20 hold cycles, release observed");
    endtask

    task automatic test_reset_in_run();
        int lat, dones;
        real err, worst;
        load_random();
        out_ready = 1'b1;
        launch(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, out_valid, done} !== 3'b000 || y_all !== '0 || cb_all !== '0 || cr_all !== '0) begin
            bad++; $display("FAIL reset_in_run: got flags=%b y0=%h want 000 / 0", {busy, out_valid, done}, word_of(y_all, 0));
        end
        load_random();
        golden(1'b0, 1'b0);
        launch(1'b0, 1'b0);
        wait_valid(lat, dones);
        total++;
        if (lat !== EXP_LAT || dones !== 1) begin bad++; $display("FAIL rerun_latency: got lat=%0d done=%0d want 11 / 1", lat, dones); end
        worst = 0.0;
        for (int i = 0; i < PC; i++) begin
            err = absr(real_of(y_all, i) - gy[i]);   if (err > worst) worst = err;
            err = absr(real_of(cb_all, i) - gcb[i]); if (err > worst) worst = err;
            err = absr(real_of(cr_all, i) - gcr[i]); if (err > worst) worst = err;
        end
        total++;
        if (worst > 32768.0) begin bad++; $display("FAIL rerun_golden: got worst error %0f want <= 32768", worst); end
        @(negedge clk);
        $display("reset during run, fresh block latency %0d", lat);
    endtask

    task automatic test_random();
        int lat, hold_n, errs_lat, errs_data, errs_hs;
        real err, worst;
        logic m, s;
        errs_lat = 0; errs_data = 0; errs_hs = 0;
        for (int blk = 0; blk < 100; blk++) begin
            m = 1'($urandom); s = 1'($urandom);
            load_random();
            golden(m, s);
            out_ready = 1'b0;
            launch(m, s);
            mode = ~m; level_shift = ~s;
            scramble_ports();
            lat = -1;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk);
                if (out_valid === 1'b1) begin lat = n; break; end
                out_ready = 1'($urandom);
            end
            total++;
            if (lat !== EXP_LAT) begin bad++; errs_lat++; $display("FAIL rand_latency blk %0d: got %0d want %0d", blk, lat, EXP_LAT); end
            worst = 0.0;
            for (int i = 0; i < PC; i++) begin
                err = absr(real_of(y_all, i) - gy[i]);   if (err > worst) worst = err;
                err = absr(real_of(cb_all, i) - gcb[i]); if (err > worst) worst = err;
                err = absr(real_of(cr_all, i) - gcr[i]); if (err > worst) worst = err;
            end
            total++;
            if (worst > 32768.0) begin bad++; errs_data++; $display("FAIL rand_golden blk %0d mode=%b shift=%b: got worst error %0f want <= 32768", blk, m, s, worst); end
            if (out_ready === 1'b0) begin
                hold_n = $urandom_range(0, 3);
                for (int h = 0; h < hold_n; h++) @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            total++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; errs_hs++; $display("FAIL rand_handshake blk %0d: got valid,busy=%b want 00", blk, {out_valid, busy}); end
            out_ready = 1'b0;
            $display("random blk %0d mode=%b shift=%b lat=%0d worst=%0f", blk, m, s, lat, worst);
        end
    endtask

    initial begin
        test_reset();
        test_jfif_zero();
        test_jfif_white();
        test_studio_and_shift();
        test_backpressure();
        test_reset_in_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb2ycbcr_block_engine.md
Name: rgb2ycbcr_block_engine

Overview:
Parametrised next-generation block colour converter. It converts a PIXEL_COUNT-pixel RGB block to Q-format Y/Cb/Cr using CORE_COUNT pipelined cores, time-multiplexed over the block.
New capabilities:
- Selectable JFIF full-range or BT.601 studio-range matrix.
- Optional JPEG level shift (-128).
- Output valid/ready handshake with hold under backpressure.
It sits between the pixel block buffer and the DCT stage of the JPEG encoder.

Parameters:
fixed_point_length, 32, output word width (signed, two's complement)
FRAC_BITS, 16, fractional bits of output (Q16.16 at default)
input_width, 8, unsigned bits per R/G/B sample
PIXEL_COUNT, 64, pixels per block; must be a multiple of CORE_COUNT
CORE_COUNT, 8, parallel conversion cores
CORE_LAT, 2, pipeline depth of each core in cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  request conversion; sampled only in IDLE
mode  in  1  0 = JFIF full range, 1 = BT.601 studio range; captured at start
level_shift  in  1  1 = subtract 128.0 from Y, Cb, Cr; captured at start
r_all/g_all/b_all  in  input_width*PIXEL_COUNT each  packed samples, pixel i at [i*input_width +: input_width]
y_all/cb_all/cr_all  out  fixed_point_length*PIXEL_COUNT each  packed results, same ordering
busy  out  1  high from the start-accept edge until the output handshake completes
out_valid  out  1  result block valid; held until accepted
out_ready  in  1  consumer accepts the block when high with out_valid
done  out  1  one-cycle pulse on the cycle out_valid first rises

Behaviour:
- Reset: state = IDLE. y_all, cb_all, cr_all, busy, out_valid and done are all 0. Batch counter = 0. Reset has priority over every other event.
- FSM IDLE -> RUN -> DRAIN -> HOLD -> IDLE.
- IDLE:
  - start=1 at an edge: capture r/g/b_all, mode and level_shift into internal registers; busy goes to 1; go to RUN.
  - Inputs may change after the capture edge without effect.
- RUN:
  - One batch of CORE_COUNT pixels is issued per cycle, batch k = pixels k*CORE_COUNT .. k*CORE_COUNT+CORE_COUNT-1.
  - N_BATCH = PIXEL_COUNT/CORE_COUNT.
  - After the last batch is issued, go to DRAIN.
- DRAIN:
  - Wait CORE_LAT cycles; a write-back of each returning batch into its output slots runs continuously.
  - Then go to HOLD with out_valid=1 and done=1 for exactly one cycle.
  - out_valid first asserts N_BATCH+CORE_LAT+1 edges after the start edge (11 at defaults).
- HOLD:
  - Outputs are stable while out_valid=1 and out_ready=0.
  - At an edge with out_ready=1: out_valid=0, busy=0, go to IDLE.
  - A start in that same cycle is ignored; it must be re-presented.
- start while busy is ignored. No queueing, no error flag.
- out_ready outside HOLD has no effect.
- y_all/cb_all/cr_all retain the last block after the handshake until the next block's write-back overwrites them.
- Arithmetic:
  - Coefficients are round-to-nearest(c*2^FRAC_BITS).
  - Products are input sample (zero-extended) * signed coefficient, summed exactly in a fixed_point_length+2 bit accumulator.
  - Offsets are added as integer<<FRAC_BITS.
  - The result is truncated to fixed_point_length bits. No saturation is needed at defaults.
  - level_shift subtracts 128<<FRAC_BITS from all three channels after the offset.
- JFIF matrix:
  - Y = .299R + .587G + .114B
  - Cb = 128 - .168736R - .331264G + .5B
  - Cr = 128 + .5R - .418688G - .081312B
- Studio matrix:
  - Y = 16 + .256788R + .504129G + .097906B
  - Cb = 128 - .148223R - .290993G + .439216B
  - Cr = 128 + .439216R - .367788G - .071427B

Decomposition:
- Package rgb2ycbcr_pkg:
  - both coefficient sets as functions of FRAC_BITS
  - offset constants (16, 128)
  - FSM state enum
  - helper for N_BATCH
- Sub-module rgb2ycbcr_core_pipe:
  - one pixel in, Y/Cb/Cr out after CORE_LAT cycles
  - mode and level_shift as inputs
  - instantiated CORE_COUNT times with generate
- The top level holds the FSM, batch mux, write-back demux and handshake.

Test Plan:
- JFIF, no shift, all pixels R=G=B=0, out_ready=1 -> every Y=0x00000000, Cb=Cr=0x00800000; done pulses once, 11 cycles after start.
- JFIF, all R=G=B=255 -> Y=0x00FF0000, Cb=Cr=0x00800000. Pixel 5 R=255, G=B=0 -> Y5=0x004C3E75.
- Studio with zeros -> Y=0x00100000, Cb=Cr=0x00800000. JFIF+level_shift with zeros -> Y=0xFF800000, Cb=Cr=0x00000000.
- Backpressure:
  - hold out_ready=0 for 20 cycles -> out_valid, busy and outputs stay constant, done pulses only once;
  - raise out_ready -> IDLE next cycle;
  - start pulses during HOLD are ignored.
- Reset asserted in RUN (batch 3) -> next cycle all outputs and flags are 0, state IDLE; a fresh start then completes correctly in 11 cycles.
- Random 100 blocks, random mode/level_shift, random out_ready -> every word within 0x8000 (0.5 LSB of integer) of the golden model.
